// File: rtl/axis_frame_gen_pkg.sv
// Shared types and helpers for the AXI-stream frame generator.
// State encodings and IFG counter sizing.
package axis_frame_gen_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] SEND = 2'd1;
    localparam logic [STATE_W-1:0] GAP  = 2'd2;

    // Zero-length gaps still need a 1-bit counter to keep widths legal.
    function automatic int ifg_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_frame_gen_len_ctr.sv
// Beat down-counter for axis_frame_gen: loads frame length,
// decrements per accepted beat, flags the final beat.
module axis_frame_gen_len_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         async_rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         is_one,
    output logic         is_zero
);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign is_one  = (cnt == W'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-stream frame source: one frame of incrementing beats per start.
// Optional tuser error marking with AXIS_FRAME_GEN_ERR_INJECT_EN.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int IFG_CYCLES = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  async_rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] start_value,
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
    input  logic                  err_inject,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser
);

    import axis_frame_gen_pkg::*;

    localparam int IFG_W = ifg_w(IFG_CYCLES);
    localparam logic [IFG_W-1:0] IFG_LAST =
        IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    logic [STATE_W-1:0]   state;
    logic [IFG_W-1:0]     ifg_cnt;
    logic                 err_q;
    logic                 err_in;
    logic [LEN_WIDTH-1:0] rem;
    logic                 is_one;
    logic                 is_zero;
    logic                 go;
    logic                 accept;
    logic                 near_end;

`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
    assign err_in = err_inject;
`else
    assign err_in = 1'b0;
`endif

    // done blocks a same-cycle restart when there is no gap.
    assign go       = start && (frame_len != '0) && !done;
    assign accept   = output_axis_tvalid && output_axis_tready;
    assign near_end = (rem == LEN_WIDTH'(2));

    axis_frame_gen_len_ctr #(
        .W (LEN_WIDTH)
    ) u_len_ctr (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .load        ((state == IDLE) && go),
        .load_val    (frame_len),
        .dec         (accept),
        .cnt         (rem),
        .is_one      (is_one),
        .is_zero     (is_zero)
    );

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state              <= IDLE;
            ifg_cnt            <= '0;
            err_q              <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            frame_count        <= '0;
            output_axis_tdata  <= '0;
            output_axis_tvalid <= 1'b0;
            output_axis_tlast  <= 1'b0;
            output_axis_tuser  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (1'b1)
                (state == IDLE): begin
                    if (go) begin
                        state              <= SEND;
                        busy               <= 1'b1;
                        err_q              <= err_in;
                        output_axis_tdata  <= start_value;
                        output_axis_tvalid <= 1'b1;
                        output_axis_tlast  <= (frame_len == LEN_WIDTH'(1));
                        output_axis_tuser  <= err_in
                            && (frame_len == LEN_WIDTH'(1));
                    end
                end
                (state == SEND): begin
                    if (accept) begin
                        output_axis_tdata <= output_axis_tdata
                            + DATA_WIDTH'(1);
                        if (is_one || is_zero) begin
                            output_axis_tvalid <= 1'b0;
                            output_axis_tlast  <= 1'b0;
                            output_axis_tuser  <= 1'b0;
                            done               <= 1'b1;
                            frame_count        <= frame_count
                                + CNT_WIDTH'(1);
                            ifg_cnt            <= '0;
                            if (IFG_CYCLES > 0) begin
                                state <= GAP;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            output_axis_tlast <= near_end;
                            output_axis_tuser <= err_q && near_end;
                        end
                    end
                end
                (state == GAP): begin
                    if (ifg_cnt == IFG_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ifg_cnt <= ifg_cnt + IFG_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed self-checking bench for axis_frame_gen.
// Beats are captured on the falling edge and compared to hand values.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        start;
    logic [7:0]  frame_len;
    logic [7:0]  start_value;
    logic        err_inject;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid;
    logic        output_axis_tready;
    logic        output_axis_tlast;
    logic        output_axis_tuser;

    int total = 0;
    int bad   = 0;
    int dones = 0;
    logic [9:0]  beats[$];
    logic [10:0] snap;
    bit          hv = 1'b0;
    logic [15:0] fc_exp = '0;

    always #5 clk = ~clk;

    axis_frame_gen dut (
        .clk                (clk),
        .async_rst_n        (async_rst_n),
        .start              (start),
        .frame_len          (frame_len),
        .start_value        (start_value),
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
        .err_inject         (err_inject),
`endif
        .busy               (busy),
        .done               (done),
        .frame_count        (frame_count),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .output_axis_tlast  (output_axis_tlast),
        .output_axis_tuser  (output_axis_tuser)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (output_axis_tvalid && output_axis_tready)
            beats.push_back({output_axis_tuser, output_axis_tlast,
                             output_axis_tdata});
        if (done) dones++;
        if (async_rst_n && hv)
            check("stall_hold",
                  {21'd0, output_axis_tvalid, output_axis_tlast,
                   output_axis_tuser, output_axis_tdata},
                  {21'd0, snap});
        hv   = async_rst_n && output_axis_tvalid && !output_axis_tready;
        snap = {output_axis_tvalid, output_axis_tlast,
                output_axis_tuser, output_axis_tdata};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] sv, input logic [7:0] len,
                               input logic err);
        start       = 1'b1;
        start_value = sv;
        frame_len   = len;
        err_inject  = err;
        tick();
        start = 1'b0;
    endtask

    // Sends one frame and checks every accepted beat against sv+i.
    task automatic send(input logic [7:0] sv, input int len, input logic err,
                        input bit toggle);
        int i;
        logic [7:0] ed;
        logic eu;
        beats.delete();
        dones = 0;
        output_axis_tready = toggle ? 1'b0 : 1'b1;
        pulse_start(sv, 8'(len), err);
        if (len != 0) begin
            check("lat_valid", {31'd0, output_axis_tvalid}, 32'd1);
            check("lat_data", {24'd0, output_axis_tdata}, {24'd0, sv});
            fc_exp++;
        end
        for (i = 0; i < 64 && dones == 0 && len != 0; i++) begin
            if (toggle) output_axis_tready = ~output_axis_tready;
            tick();
        end
        if (len != 0 && dones == 0) check("done_timeout", 0, 1);
        output_axis_tready = 1'b1;
        for (i = 0; i < 16 && busy; i++) tick();
        repeat (2) tick();
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("beat_cnt", beats.size(), len);
        check("done_cnt", dones, (len != 0) ? 1 : 0);
        check("frame_count", {16'd0, frame_count}, {16'd0, fc_exp});
        for (int k = 0; k < beats.size() && k < len; k++) begin
            ed = sv + 8'(k);
`ifdef AXIS_FRAME_GEN_ERR_INJECT_EN
            eu = err && (k == len - 1);
`else
            eu = 1'b0;
`endif
            check("beat", {22'd0, beats[k]},
                  {22'd0, eu, (k == len - 1), ed});
        end
    endtask

    initial begin
        async_rst_n        = 1'b0;
        start              = 1'b1;
        frame_len          = 8'd4;
        start_value        = 8'h01;
        err_inject         = 1'b0;
        output_axis_tready = 1'b1;
        repeat (5) tick();
        check("rst_valid", {31'd0, output_axis_tvalid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fc", {16'd0, frame_count}, 32'd0);
        check("rst_beats", beats.size(), 0);
        start       = 1'b0;
        async_rst_n = 1'b1;
        repeat (2) tick();

        send(8'h01, 4, 1'b0, 1'b0);
        send(8'h01, 3, 1'b0, 1'b1);
        send(8'hFE, 3, 1'b0, 1'b0);
        check("wrap_zero", {24'd0, beats[2][7:0]}, 32'h00);
        send(8'h40, 1, 1'b0, 1'b0);
        send(8'h50, 0, 1'b0, 1'b0);

        beats.delete();
        dones = 0;
        output_axis_tready = 1'b1;
        pulse_start(8'h10, 8'd6, 1'b0);
        tick();
        tick();
        async_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, output_axis_tvalid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) tick();
        async_rst_n = 1'b1;
        fc_exp = '0;
        repeat (2) tick();
        check("mid_rst_done", dones, 0);
        check("mid_rst_fc", {16'd0, frame_count}, 32'd0);
        send(8'h20, 6, 1'b0, 1'b0);

        beats.delete();
        dones = 0;
        pulse_start(8'h70, 8'd1, 1'b0);
        tick();
        check("done_pulse", {31'd0, done}, 32'd1);
        pulse_start(8'h80, 8'd2, 1'b0);
        pulse_start(8'h90, 8'd2, 1'b0);
        repeat (6) tick();
        check("gap_ignore", beats.size(), 1);
        check("gap_busy", {31'd0, busy}, 32'd0);
        fc_exp++;
        check("gap_fc", {16'd0, frame_count}, {16'd0, fc_exp});

        send(8'hA0, 3, 1'b1, 1'b0);
        send(8'hB0, 3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
